// File: rtl/dmem_stage_if.sv
// dmem_stage_if: bundle of the MEM-stage memory access signals.
//   master : EX/MEM side. It drives the access request and reads the results.
//   slave  : dmem_stage. It receives the request and drives the load data,
//            the fault flags, the counters and the first-fault record.
// The signal names follow the pipeline names used elsewhere in the core.
interface dmem_stage_if;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [2:0]  MEM_MemOp;
  logic [31:0] MEM_AluOut;
  logic [31:0] MEM_WriteData;
  logic        MEM_undefine;
  logic        MEM_overflow;

  logic [31:0] dm_out;
  logic        MEM_misalign;
  logic        MEM_oob;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic        fault_valid;
  logic [31:0] fault_addr;

  modport master (
    output MEM_MemRead, MEM_MemWrite, MEM_MemOp, MEM_AluOut, MEM_WriteData,
           MEM_undefine, MEM_overflow,
    input  dm_out, MEM_misalign, MEM_oob, load_cnt, store_cnt,
           fault_valid, fault_addr
  );

  modport slave (
    input  MEM_MemRead, MEM_MemWrite, MEM_MemOp, MEM_AluOut, MEM_WriteData,
           MEM_undefine, MEM_overflow,
    output dm_out, MEM_misalign, MEM_oob, load_cnt, store_cnt,
           fault_valid, fault_addr
  );
endinterface

// File: rtl/dmem_stage.sv
// dmem_stage: data-memory access stage of the five-stage pipeline.
// It holds a little-endian, word-organised RAM of DEPTH_WORDS words. It
// performs word, half and byte stores, and returns the extended load data
// combinationally. It flags misaligned and out-of-range accesses, drops
// stores from faulting instructions, and keeps saturating load/store
// counters plus a sticky record of the first fault.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset. It clears the RAM, the counters
//         and the fault record.
//   bus : dmem_stage_if.slave. Carries the request (MemRead/MemWrite/MemOp/
//         AluOut/WriteData/undefine/overflow) and the results (dm_out,
//         misalign, oob, load_cnt, store_cnt, fault_valid, fault_addr).
module dmem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic         clk,
  input  logic         rst,
  dmem_stage_if.slave  bus
);

  // 33 bits so that the comparison never wraps, even for a RAM that
  // fills the whole 32-bit byte space.
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_load_cnt;
  logic [31:0] r_store_cnt;
  logic        r_fault_valid;
  logic [31:0] r_fault_addr;

  logic          w_acc;
  logic          w_is_word;
  logic          w_is_half;
  logic          w_is_byte;
  logic          w_illegal;
  logic          w_oob;
  logic          w_misalign;
  logic          w_fault;
  logic          w_ok;
  logic          w_we;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  assign w_acc     = bus.MEM_MemRead | bus.MEM_MemWrite;
  assign w_is_word = (bus.MEM_MemOp == 3'd0);
  assign w_is_half = (bus.MEM_MemOp == 3'd1) | (bus.MEM_MemOp == 3'd2);
  assign w_is_byte = (bus.MEM_MemOp == 3'd3) | (bus.MEM_MemOp == 3'd4);
  assign w_illegal = ~(w_is_word | w_is_half | w_is_byte);

  assign w_oob      = w_acc & ({1'b0, bus.MEM_AluOut} >= LIMIT);
  assign w_misalign = w_acc & ((w_is_word & (bus.MEM_AluOut[1:0] != 2'b00)) |
                               (w_is_half & bus.MEM_AluOut[0]) |
                               w_illegal |
                               (bus.MEM_MemRead & bus.MEM_MemWrite));
  assign w_fault    = w_misalign | w_oob;
  assign w_ok       = ~w_fault & ~bus.MEM_undefine & ~bus.MEM_overflow;
  assign w_we       = bus.MEM_MemWrite & w_ok;

  assign w_idx  = bus.MEM_AluOut[AW+1:2];
  assign w_lane = bus.MEM_AluOut[1:0];

  // Load path. The RAM read is unconditional, because an out-of-range index
  // still lands inside the array. The result is zeroed by the qualifier.
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (bus.MEM_MemOp)
      3'd0:    w_ext = w_word;
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd2:    w_ext = {16'h0, w_half};
      3'd3:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_ext = {24'h0, w_byte};
      default: w_ext = 32'h0;
    endcase
  end

  assign bus.dm_out       = (bus.MEM_MemRead & w_ok) ? w_ext : 32'h0;
  assign bus.MEM_misalign = w_misalign;
  assign bus.MEM_oob      = w_oob;

  // Store path. The data is replicated across the lanes so that the byte
  // enables alone pick which bytes land.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.MEM_WriteData;
    if (w_is_word) begin
      w_be    = 4'b1111;
      w_wdata = bus.MEM_WriteData;
    end else if (w_is_half) begin
      w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.MEM_WriteData[15:0]}};
    end else if (w_is_byte) begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{bus.MEM_WriteData[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
      r_load_cnt    <= 32'h0;
      r_store_cnt   <= 32'h0;
      r_fault_valid <= 1'b0;
      r_fault_addr  <= 32'h0;
    end else begin
      if (w_we) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        if (r_store_cnt != 32'hFFFF_FFFF) r_store_cnt <= r_store_cnt + 32'd1;
      end
      if (bus.MEM_MemRead & w_ok && r_load_cnt != 32'hFFFF_FFFF)
        r_load_cnt <= r_load_cnt + 32'd1;
      // The fault record ignores undefine/overflow: it captures every fault.
      if (w_fault & ~r_fault_valid) begin
        r_fault_valid <= 1'b1;
        r_fault_addr  <= bus.MEM_AluOut;
      end
    end
  end

  assign bus.load_cnt    = r_load_cnt;
  assign bus.store_cnt   = r_store_cnt;
  assign bus.fault_valid = r_fault_valid;
  assign bus.fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: self-checking bench for dmem_stage.
// The reference model treats the RAM as a flat array of bytes. It computes
// loads as sums of shifted bytes, with sign extension done by subtraction.
module tb_dmem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_stage_if bus ();

  dmem_stage #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // current stimulus
  logic        i_rd, i_wr, i_und, i_ovf, i_rst;
  logic [2:0]  i_op;
  logic [31:0] i_addr, i_wd;

  // model state and expectations
  logic [7:0]  m_mem [0:4095];
  logic [31:0] m_load, m_store, m_fa;
  logic        m_fv;
  logic [31:0] e_dm;
  logic        e_mis, e_oob, e_ok;
  int          e_size;

  task automatic model_eval();
    logic [63:0] v;
    logic acc;
    acc = i_rd | i_wr;
    e_oob = acc && (i_addr >= 32'h1000);
    case (i_op)
      3'd0:       e_size = 4;
      3'd1, 3'd2: e_size = 2;
      3'd3, 3'd4: e_size = 1;
      default:    e_size = 0;
    endcase
    e_mis = acc && (e_size == 0 || (i_rd && i_wr) ||
                    (e_size != 0 && (i_addr % e_size) != 0));
    e_ok = !(e_mis || e_oob) && !i_und && !i_ovf;
    v = 64'd0;
    if (i_rd && e_ok) begin
      for (int k = 0; k < e_size; k++) v = v + (64'(m_mem[i_addr + k]) << (8 * k));
      if ((i_op == 3'd1 || i_op == 3'd3) && v[8 * e_size - 1]) v = v - (64'd1 << (8 * e_size));
    end
    e_dm = v[31:0];
  endtask

  task automatic model_commit();
    if (i_rst) begin
      for (int a = 0; a < 4096; a++) m_mem[a] = 8'h00;
      m_load = 0; m_store = 0; m_fv = 0; m_fa = 0;
    end else begin
      if (i_wr && e_ok) begin
        for (int k = 0; k < e_size; k++) m_mem[i_addr + k] = 8'((i_wd >> (8 * k)) & 32'hFF);
        if (m_store != 32'hFFFF_FFFF) m_store = m_store + 1;
      end
      if (i_rd && e_ok && m_load != 32'hFFFF_FFFF) m_load = m_load + 1;
      if ((e_mis || e_oob) && !m_fv) begin
        m_fv = 1'b1;
        m_fa = i_addr;
      end
    end
  endtask

  // Drive one access. Returns at the falling edge, where the combinational
  // outputs are checked.
  task automatic apply(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic und, input logic ovf, input logic r);
    i_rd = rd; i_wr = wr; i_op = op; i_addr = addr; i_wd = wd;
    i_und = und; i_ovf = ovf; i_rst = r;
    bus.MEM_MemRead = rd; bus.MEM_MemWrite = wr; bus.MEM_MemOp = op;
    bus.MEM_AluOut = addr; bus.MEM_WriteData = wd;
    bus.MEM_undefine = und; bus.MEM_overflow = ovf;
    rst = r;
    model_eval();
    @(negedge clk);
  endtask

  // Finish the cycle. Returns just after the rising edge.
  task automatic commit();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 1);
    commit();
    checks++; if (bus.load_cnt !== 32'h0) begin failures++; $display("FAIL reset_load_cnt got=%h exp=0", bus.load_cnt); end
    checks++; if (bus.store_cnt !== 32'h0) begin failures++; $display("FAIL reset_store_cnt got=%h exp=0", bus.store_cnt); end
    checks++; if (bus.fault_valid !== 1'b0 || bus.fault_addr !== 32'h0) begin failures++; $display("FAIL reset_fault got=%b/%h exp=0/0", bus.fault_valid, bus.fault_addr); end
    apply(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h0) begin failures++; $display("FAIL reset_ram got=%h exp=0", bus.dm_out); end
    commit();
    apply(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 1);
    commit();
  endtask

  task automatic test_word();
    apply(0, 1, 3'd0, 32'h10, 32'h8040_20FF, 0, 0, 0);
    commit();
    apply(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h8040_20FF) begin failures++; $display("FAIL word_rt got=%h exp=%h", bus.dm_out, 32'h8040_20FF); end
    commit();
    checks++; if (bus.store_cnt !== 32'd1 || bus.load_cnt !== 32'd1) begin failures++; $display("FAIL word_cnts got=%0d/%0d exp=1/1", bus.store_cnt, bus.load_cnt); end
  endtask

  task automatic test_extend();
    logic [2:0]  ops  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd1};
    logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8040, 32'h0000_20FF, 32'h0000_20FF};
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, ops[i], adrs[i], 32'h0, 0, 0, 0);
      checks++; if (bus.dm_out !== exps[i]) begin failures++; $display("FAIL extend[%0d] got=%h exp=%h", i, bus.dm_out, exps[i]); end
      commit();
    end
    apply(0, 1, 3'd3, 32'h11, 32'h1234_56AA, 0, 0, 0);
    commit();
    apply(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h8040_AAFF) begin failures++; $display("FAIL sb_merge got=%h exp=%h", bus.dm_out, 32'h8040_AAFF); end
    commit();
    apply(0, 1, 3'd1, 32'h12, 32'hFFFF_5566, 0, 0, 0);
    commit();
    apply(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h5566_AAFF) begin failures++; $display("FAIL sh_merge got=%h exp=%h", bus.dm_out, 32'h5566_AAFF); end
    commit();
  endtask

  task automatic test_misalign();
    apply(0, 1, 3'd0, 32'h20, 32'hDEAD_BEEF, 0, 0, 0);
    commit();
    apply(1, 0, 3'd0, 32'h22, 32'h0, 0, 0, 0);
    checks++; if (bus.MEM_misalign !== 1'b1 || bus.dm_out !== 32'h0) begin failures++; $display("FAIL lw_misalign got=%b/%h exp=1/0", bus.MEM_misalign, bus.dm_out); end
    commit();
    checks++; if (bus.fault_valid !== 1'b1 || bus.fault_addr !== 32'h22) begin failures++; $display("FAIL first_fault got=%b/%h exp=1/22", bus.fault_valid, bus.fault_addr); end
    apply(0, 1, 3'd1, 32'h21, 32'h0000_1111, 0, 0, 0);
    checks++; if (bus.MEM_misalign !== 1'b1) begin failures++; $display("FAIL sh_misalign got=%b exp=1", bus.MEM_misalign); end
    commit();
    apply(1, 0, 3'd0, 32'h20, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sh_dropped got=%h exp=%h", bus.dm_out, 32'hDEAD_BEEF); end
    commit();
    checks++; if (bus.fault_addr !== 32'h22) begin failures++; $display("FAIL fault_sticky got=%h exp=22", bus.fault_addr); end
    apply(1, 0, 3'd6, 32'h20, 32'h0, 0, 0, 0);
    checks++; if (bus.MEM_misalign !== 1'b1) begin failures++; $display("FAIL illegal_op got=%b exp=1", bus.MEM_misalign); end
    commit();
    apply(1, 1, 3'd0, 32'h20, 32'h0, 0, 0, 0);
    checks++; if (bus.MEM_misalign !== 1'b1) begin failures++; $display("FAIL rd_and_wr got=%b exp=1", bus.MEM_misalign); end
    commit();
  endtask

  task automatic test_oob();
    logic [31:0] sc;
    sc = bus.store_cnt;
    apply(0, 1, 3'd0, 32'h1000, 32'h5A5A_5A5A, 0, 0, 0);
    checks++; if (bus.MEM_oob !== 1'b1) begin failures++; $display("FAIL oob_flag got=%b exp=1", bus.MEM_oob); end
    commit();
    checks++; if (bus.store_cnt !== sc) begin failures++; $display("FAIL oob_store_cnt got=%0d exp=%0d", bus.store_cnt, sc); end
    apply(0, 1, 3'd0, 32'hFFC, 32'h1357_2468, 0, 0, 0);
    checks++; if (bus.MEM_oob !== 1'b0) begin failures++; $display("FAIL last_word_oob got=%b exp=0", bus.MEM_oob); end
    commit();
    apply(1, 0, 3'd0, 32'hFFC, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h1357_2468) begin failures++; $display("FAIL last_word got=%h exp=%h", bus.dm_out, 32'h1357_2468); end
    commit();
    apply(0, 1, 3'd0, 32'h4000_0010, 32'h0BAD_0BAD, 0, 0, 0);
    checks++; if (bus.MEM_oob !== 1'b1) begin failures++; $display("FAIL alias_oob got=%b exp=1", bus.MEM_oob); end
    commit();
    apply(1, 0, 3'd0, 32'h10, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h5566_AAFF) begin failures++; $display("FAIL no_alias got=%h exp=%h", bus.dm_out, 32'h5566_AAFF); end
    commit();
  endtask

  task automatic test_suppress();
    logic [31:0] lc, sc;
    lc = bus.load_cnt; sc = bus.store_cnt;
    apply(0, 1, 3'd0, 32'h30, 32'h0000_1234, 0, 1, 0);
    commit();
    apply(1, 0, 3'd0, 32'h30, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_out !== 32'h0) begin failures++; $display("FAIL suppress_ram got=%h exp=0", bus.dm_out); end
    commit();
    checks++; if (bus.load_cnt !== lc + 1 || bus.store_cnt !== sc) begin failures++; $display("FAIL suppress_cnts got=%0d/%0d exp=%0d/%0d", bus.load_cnt, bus.store_cnt, lc + 1, sc); end
    apply(1, 0, 3'd0, 32'h10, 32'h0, 1, 0, 0);
    checks++; if (bus.dm_out !== 32'h0) begin failures++; $display("FAIL undef_load got=%h exp=0", bus.dm_out); end
    commit();
  endtask

  task automatic test_reset_burst();
    apply(0, 1, 3'd0, 32'h50, 32'h1111_1111, 0, 0, 0); commit();
    apply(0, 1, 3'd0, 32'h54, 32'h2222_2222, 0, 0, 0); commit();
    apply(0, 1, 3'd0, 32'h58, 32'h3333_3333, 0, 0, 1); commit();
    checks++; if (bus.load_cnt !== 0 || bus.store_cnt !== 0 || bus.fault_valid !== 0 || bus.fault_addr !== 0) begin
      failures++; $display("FAIL burst_reset got=%0d/%0d/%b/%h exp=0/0/0/0", bus.load_cnt, bus.store_cnt, bus.fault_valid, bus.fault_addr);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 3'd0, 32'h50 + 4 * i, 32'h0, 0, 0, 0);
      checks++; if (bus.dm_out !== 32'h0) begin failures++; $display("FAIL burst_ram[%0d] got=%h exp=0", i, bus.dm_out); end
      commit();
    end
    checks++; if (bus.load_cnt !== 32'd3) begin failures++; $display("FAIL after_reset_loads got=%0d exp=3", bus.load_cnt); end
  endtask

  task automatic test_random();
    logic rd, wr, und, ovf, r;
    logic [2:0] op;
    logic [31:0] addr;
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 8)
        0, 1, 2: begin rd = 1; wr = 0; end
        3, 4, 5: begin rd = 0; wr = 1; end
        6:       begin rd = 1; wr = 1; end
        default: begin rd = 0; wr = 0; end
      endcase
      op = ($urandom % 4 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      case ($urandom % 8)
        5:       addr = 32'hFF8 + ($urandom % 16);
        6:       addr = $urandom;
        default: addr = 32'h40 + ($urandom % 32);
      endcase
      und = ($urandom % 10 == 0);
      ovf = ($urandom % 10 == 0);
      r   = ($urandom % 60 == 0);
      apply(rd, wr, op, addr, $urandom, und, ovf, r);
      checks++; if (bus.dm_out !== e_dm) begin failures++; $display("FAIL rnd_dm[%0d] got=%h exp=%h", n, bus.dm_out, e_dm); end
      checks++; if (bus.MEM_misalign !== e_mis || bus.MEM_oob !== e_oob) begin failures++; $display("FAIL rnd_flags[%0d] got=%b%b exp=%b%b", n, bus.MEM_misalign, bus.MEM_oob, e_mis, e_oob); end
      commit();
      checks++; if (bus.load_cnt !== m_load || bus.store_cnt !== m_store) begin failures++; $display("FAIL rnd_cnts[%0d] got=%0d/%0d exp=%0d/%0d", n, bus.load_cnt, bus.store_cnt, m_load, m_store); end
      checks++; if (bus.fault_valid !== m_fv || bus.fault_addr !== m_fa) begin failures++; $display("FAIL rnd_fault[%0d] got=%b/%h exp=%b/%h", n, bus.fault_valid, bus.fault_addr, m_fv, m_fa); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_misalign();
    test_oob();
    test_suppress();
    test_reset_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
